main_fsm: RTL
=============

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: USE_MEM_READY, default 1; when 0, mem_ready is ignored and treated as constant 1.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 mem_req  out  1  memory access in progress (FETCH, MEMRD, MEMWR).
REQ-008 iord  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
REQ-009 mem_write  out  1  memory write strobe.
REQ-010 ir_write  out  1  instruction register load.
REQ-011 reg_dst  out  1  1 = rd destination; 0 = rt destination.
REQ-012 memto_reg  out  1  1 = write-back from memory data; 0 = write-back from ALUOut.
REQ-013 reg_write  out  1  register file write enable.
REQ-014 alu_src_a  out  1  0 = PC; 1 = register A.
REQ-015 alu_src_b  out  2  00 = B; 01 = constant 4; 10 = sign-extended immediate; 11 = shifted immediate.
REQ-016 alu_op  out  2  00 = add; 01 = subtract; 10 = decode from funct. Drives the ALU decoder.
REQ-017 pc_src  out  2  00 = ALU result; 01 = ALUOut; 10 = jump target.
REQ-018 pc_en  out  1  PC load enable.
REQ-019 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-020 state  out  4  current state code, for debug.

Function
REQ-021 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-022 All outputs SHALL be Moore functions of the state, except pc_en, ir_write, illegal_op and the mem_ready qualification; any output not listed for a state SHALL be 0.
REQ-023 FETCH: mem_req=1, alu_src_b=01, ir_write=mem_ready, pc write=mem_ready; the FSM SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-024 DECODE: alu_src_b=11. Next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other op -> FETCH, with illegal_op=1 for that cycle.
REQ-025 MEMADR: alu_src_a=1, alu_src_b=10; next state MEMRD if op=100011, else MEMWR.
REQ-026 MEMRD: mem_req=1, iord=1; stay until mem_ready=1, then MEMWB.
REQ-027 MEMWB: memto_reg=1, reg_write=1; next state FETCH.
REQ-028 MEMWR: mem_req=1, iord=1, mem_write=1 for every cycle in the state; stay until mem_ready=1, then FETCH.
REQ-029 EXECUTE: alu_src_a=1, alu_op=10; next state ALUWB.
REQ-030 ALUWB: reg_dst=1, reg_write=1; next state FETCH.
REQ-031 BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1; next state FETCH.
REQ-032 ADDIEX: alu_src_a=1, alu_src_b=10; next state ADDIWB.
REQ-033 ADDIWB: reg_write=1; next state FETCH.
REQ-034 JUMP: pc_src=10, pc write=1; next state FETCH.
REQ-035 pc_en SHALL equal pc_write OR (branch AND zero), combinationally.
REQ-036 Unused state codes 12..15 SHALL transition to FETCH on the next clock, with all outputs 0.
REQ-037 Cycle counts with mem_ready held at 1:
- lw = 5 cycles; sw = 4; R-type = 4; addi = 4; beq = 3; j = 3
- each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
REQ-038 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-039 rst_n=0 SHALL force state=FETCH immediately, independent of clk.
REQ-040 While rst_n=0, all outputs SHALL be 0 except mem_req=1 and alu_src_b=01 (FETCH Moore values); ir_write and pc_en SHALL be 0.
REQ-041 Reset asserted mid-instruction SHALL abort the instruction with no further reg_write or mem_write; the first fetch SHALL follow release of rst_n.

Verification
REQ-042 lw, op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4, with memto_reg=1.
REQ-043 sw, with mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for exactly 4 cycles, then state=0.
REQ-044 beq, zero=1 -> pc_en=1 in BRANCH with pc_src=01 and alu_op=01; with zero=0 -> pc_en=0 in BRANCH.
REQ-045 R-type, op=000000 -> alu_op=10 in EXECUTE, then reg_dst=1 and reg_write=1 in ALUWB; j, op=000010 -> pc_src=10 and pc_en=1 in JUMP.
REQ-046 op=111111 -> illegal_op pulses 1 cycle in DECODE, then state=0, with no reg_write or mem_write.
REQ-047 rst_n asserted low in MEMWR while mem_ready=0 -> state=0 and mem_write=0 within the same cycle; after release, one FETCH completes normally.

Source files
------------

// File: rtl/main_fsm.sv
// Multicycle MIPS-style control unit: Moore state machine with a mem_ready
// handshake on FETCH/MEMRD/MEMWR and a combinational PC-enable.
module main_fsm #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Moore control word; pc_write/ir_load are later qualified by mem_ready.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_load;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_rdy;
  logic       op_legal;
  ctrl_t      ctrl;

  assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_comb begin
    op_legal = 1'b0;
    unique case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_load   = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE:  ctrl.alu_src_b = SRCB_SHIFT;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB:  ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default:   ctrl = '0;
    endcase
  end

  // In FETCH the PC/IR loads wait for the memory handshake; JUMP loads at once.
  // Both are forced low while reset is held, even though state reads FETCH.
  logic pc_write_q;
  assign pc_write_q = ctrl.pc_write & ((state_q != S_FETCH) | mem_rdy);

  assign mem_req    = ctrl.mem_req;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = rst_n & ctrl.ir_load & mem_rdy;
  assign reg_dst    = ctrl.reg_dst;
  assign memto_reg  = ctrl.memto_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ALU_ADD | ctrl.alu_op;
  assign pc_src     = PC_ALU | ctrl.pc_src;
  assign pc_en      = rst_n & (pc_write_q | (ctrl.branch & zero));
  assign illegal_op = (state_q == S_DECODE) & ~op_legal;
  assign state      = state_q;

endmodule
